// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// RV32 opcode constants and the bundle of pipeline-register controls.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_EX_WAIT  = 2'd2
  } hz_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
    logic exmem_bubble;
    logic memwb_bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/reg_use_decode.sv
// Decodes which source-register fields an ID-stage opcode actually reads,
// so immediate bits sitting in rs1/rs2 positions never raise a false hazard.
module reg_use_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    unique case (opcode_i)
      OPC_LUI, OPC_AUIPC, OPC_JAL:   uses_rs1_o = 1'b0;
      default:                       uses_rs1_o = 1'b1;
    endcase
    unique case (opcode_i)
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2_o = 1'b1;
      default:                       uses_rs2_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised freeze/stall/flush rules with a
// small wait FSM and saturating stall/flush performance counters.
//
// state       | meaning
// RUN         | no multi-cycle wait in progress
// MEM_WAIT    | data-memory access outstanding, whole pipe frozen until ready
// EX_WAIT     | multi-cycle EX unit busy, front end held, bubbles into MEM
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instruction_IFID,
  input  logic [31:0]      Instruction_IDEX,
  input  logic             MemRead_IDEX,
  input  logic             branch_taken_EX,
  input  logic             ex_busy,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic             clr_counters,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_o
);

  hz_state_e   state_q, state_d;
  stage_ctrl_t ctrl;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic stall_fire, flush_fire;
  logic uses_rs1, uses_rs2;
  logic r1_freeze, r2_exwait, r3_flush, r4_loaduse;

  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       unused_bits;

  assign rs1_id = Instruction_IFID[19:15];
  assign rs2_id = Instruction_IFID[24:20];
  assign rd_ex  = Instruction_IDEX[11:7];
  assign unused_bits = ^{Instruction_IFID[31:25], Instruction_IFID[14:7],
                         Instruction_IDEX[31:12], Instruction_IDEX[6:0]};

  reg_use_decode u_reg_use_decode (
    .opcode_i   (Instruction_IFID[6:0]),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  // A taken branch needs no storage while frozen: the freeze keeps it in EX.
  assign r1_freeze  = (dmem_req_MEM || (state_q == ST_MEM_WAIT)) && !dmem_ready;
  assign r2_exwait  = ex_busy;
  assign r3_flush   = branch_taken_EX;
  assign r4_loaduse = MemRead_IDEX && (rd_ex != 5'd0) &&
                      ((uses_rs1 && (rd_ex == rs1_id)) ||
                       (uses_rs2 && (rd_ex == rs2_id)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (r1_freeze)      state_d = ST_MEM_WAIT;
        else if (r2_exwait) state_d = ST_EX_WAIT;
      end
      ST_MEM_WAIT: begin
        if (dmem_ready)     state_d = ST_RUN;
      end
      ST_EX_WAIT: begin
        if (r1_freeze)      state_d = ST_MEM_WAIT;
        else if (!ex_busy)  state_d = ST_RUN;
      end
      default:              state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    stall_fire = 1'b0;
    flush_fire = 1'b0;
    if (r1_freeze) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.ifid_stall   = 1'b1;
      ctrl.idex_stall   = 1'b1;
      ctrl.exmem_stall  = 1'b1;
      ctrl.memwb_bubble = 1'b1;
      stall_fire        = 1'b1;
    end else if (r2_exwait) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.ifid_stall   = 1'b1;
      ctrl.idex_stall   = 1'b1;
      ctrl.exmem_bubble = 1'b1;
      stall_fire        = 1'b1;
    end else if (r3_flush) begin
      ctrl.ifid_flush   = 1'b1;
      ctrl.idex_bubble  = 1'b1;
      flush_fire        = 1'b1;
    end else if (r4_loaduse) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.ifid_stall   = 1'b1;
      ctrl.idex_bubble  = 1'b1;
      stall_fire        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (clr_counters) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_fire && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_fire && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign ifid_stall   = ctrl.ifid_stall;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_stall   = ctrl.idex_stall;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_stall  = ctrl.exmem_stall;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign state_o      = state_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port clk  input  1  single pipeline clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port Instruction_IFID  input  32  instruction in ID stage (rs1 [19:15], rs2 [24:20], opcode [6:0]).
REQ-005 SHALL have port Instruction_IDEX  input  32  instruction in EX stage (rd [11:7]).
REQ-006 SHALL have port MemRead_IDEX  input  1  EX-stage instruction is a load.
REQ-007 SHALL have port branch_taken_EX  input  1  EX resolved a taken branch or jump.
REQ-008 SHALL have port ex_busy  input  1  multi-cycle EX unit (mul/div) not done.
REQ-009 SHALL have port dmem_req_MEM  input  1  MEM stage has a data-memory access outstanding.
REQ-010 SHALL have port dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 SHALL have port clr_counters  input  1  synchronous clear of the performance counters.
REQ-012 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, exmem_bubble, memwb_bubble, each output 1, pipeline-register controls.
REQ-013 SHALL have port stall_cycles  output  CNT_W  cycles in which any stall rule fired.
REQ-014 SHALL have port flush_count  output  CNT_W  number of branch flushes.
REQ-015 SHALL have port state_o  output  2  current FSM state (RUN=0, MEM_WAIT=1, EX_WAIT=2).

Function
REQ-016 SHALL derive all stage controls combinationally from state and inputs in the same cycle (zero latency), applying rules in strict priority R1>R2>R3>R4; only the highest active rule drives outputs; all other outputs remain 0.
REQ-017 R1 mem-freeze: active when (dmem_req_MEM or state==MEM_WAIT) and !dmem_ready -> pc_stall, ifid_stall, idex_stall, exmem_stall=1, memwb_bubble=1.
REQ-018 R2 ex-wait: active when ex_busy -> pc_stall, ifid_stall, idex_stall=1, exmem_bubble=1.
REQ-019 R3 branch flush: active when branch_taken_EX -> ifid_flush=1, idex_bubble=1; load-use is suppressed that cycle.
REQ-020 R4 load-use: MemRead_IDEX and rd!=0 and ((uses_rs1 and rd==rs1) or (uses_rs2 and rd==rs2)) -> pc_stall, ifid_stall, idex_bubble=1, exactly one cycle per hazard.
REQ-021 uses_rs1 SHALL be 0 for opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, else 1; uses_rs2 SHALL be 1 only for opcodes 0110011, 0100011, 1100011.
REQ-022 FSM: RUN->MEM_WAIT when R1 active; MEM_WAIT->RUN on dmem_ready (freeze released that same cycle); RUN->EX_WAIT when R2 active and R1 inactive; EX_WAIT->RUN when ex_busy falls; EX_WAIT->MEM_WAIT if R1 becomes active.
REQ-023 A branch_taken_EX arriving during R1/R2 SHALL be deferred, not lost: it is held in EX by the freeze and acted on in the first unfrozen cycle.
REQ-024 stall_cycles SHALL increment by 1 in each cycle R1, R2 or R4 is active; flush_count by 1 each R3 cycle; both saturate at all-ones.
REQ-025 clr_counters SHALL zero both counters next edge, taking precedence over a same-cycle increment.

Reset
REQ-026 On rst_n low: state=RUN, stall_cycles=0, flush_count=0, immediately and independent of clk.
REQ-027 After reset, stage controls SHALL follow REQ-016 from the inputs alone (no residual freeze); reset during MEM_WAIT abandons the wait.

Structure
REQ-028 State encoding enum and opcode constants (LUI, AUIPC, JAL, OP, STORE, BRANCH) SHALL live in shared package cpu_pkg.
REQ-029 Register-use decode SHALL be one sub-module, reg_use_decode (opcode in, uses_rs1/uses_rs2 out); no other hierarchy.

Verification
REQ-030 Load x5 in EX, ADD x6,x5,x7 in ID -> one cycle pc_stall=ifid_stall=idex_bubble=1, stall_cycles 0->1; same with rd=x0 -> no stall.
REQ-031 dmem_req_MEM=1, dmem_ready=0 for 3 cycles then 1 -> state_o=1 for 3 cycles, freeze outputs 3 cycles, released on ready cycle, stall_cycles=3.
REQ-032 branch_taken_EX=1 with load-use also present -> ifid_flush=idex_bubble=1, pc_stall=0, flush_count=1.
REQ-033 ex_busy 4 cycles with branch_taken_EX held -> exmem_bubble 4 cycles, flush on 5th cycle, state EX_WAIT->RUN.
REQ-034 Counter preset near all-ones via 2^CNT_W-1 stalls (CNT_W=4): stays 15; clr_counters with stall same cycle -> 0.
REQ-035 rst_n asserted mid MEM_WAIT -> state_o=0, counters 0 before next clk edge.
